// File: rtl/cpu_types_pkg.sv
// cpu_types_pkg: shared CPU types -- data word, RAM status and memory arbiter state
package cpu_types_pkg;
    typedef logic [31:0] word_t;
    typedef enum logic [1:0] {FREE, BUSY, ACCESS, ERROR} ramstate_t;
    typedef enum logic [1:0] {IDLE, IGRANT, DGRANT} arb_state_t;
endpackage

// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: cache-side and RAM-side signals of the memory arbiter
//   icache : iREN, iaddr -> iwait, iload
//   dcache : dREN, dWEN, daddr, dstore -> dwait, dload
//   RAM    : ramREN, ramWEN, ramaddr, ramstore -> ramload, ramstate
//   slave  : arbiter view; master : view of the caches plus RAM model
interface mem_arbiter_if;
    import cpu_types_pkg::*;
    logic iREN, iwait, dREN, dWEN, dwait, ramREN, ramWEN;
    word_t iaddr, iload, daddr, dstore, dload, ramaddr, ramstore, ramload;
    ramstate_t ramstate;
    modport slave (
        input iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
        output iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore
    );
    modport master (
        output iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
        input iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore
    );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: arbitrates icache and dcache onto one RAM port with dcache priority and icache starvation guard
//   CLK  : rising-edge clock
//   nRST : asynchronous active-low reset
//   bus  : mem_arbiter_if.slave (cache requests/responses and RAM strobes/status)
module mem_arbiter
    import cpu_types_pkg::*;
#(
    parameter int STARVE_MAX = 4
) (
    input logic CLK,
    input logic nRST,
    mem_arbiter_if.slave bus
);
    localparam int CW = $clog2(STARVE_MAX + 1);
    arb_state_t state, nxt;
    logic [CW-1:0] starve_cnt, starve_nxt;
    logic dreq;
    assign dreq = bus.dREN | bus.dWEN;
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state <= IDLE;
            starve_cnt <= '0;
        end else begin
            state <= nxt;
            starve_cnt <= starve_nxt;
        end
    end
    always_comb begin
        nxt = state;
        starve_nxt = starve_cnt;
        bus.ramREN = 1'b0;
        bus.ramWEN = 1'b0;
        bus.ramaddr = '0;
        bus.ramstore = '0;
        bus.iwait = 1'b1;
        bus.dwait = 1'b1;
        bus.iload = bus.ramload;
        bus.dload = bus.ramload;
        case (state)
            IDLE: nxt = dreq ? ((bus.iREN && starve_cnt == CW'(STARVE_MAX)) ? IGRANT : DGRANT)
                             : (bus.iREN ? IGRANT : IDLE);
            IGRANT: begin
                bus.ramaddr = bus.iaddr;
                if (!bus.iREN) nxt = IDLE;
                else begin
                    bus.ramREN = 1'b1;
                    if (bus.ramstate == ACCESS) begin
                        bus.iwait = 1'b0;
                        nxt = IDLE;
                        starve_nxt = '0;
                    end
                end
            end
            DGRANT: begin
                bus.ramaddr = bus.daddr;
                bus.ramstore = bus.dstore;
                if (!dreq) nxt = IDLE;
                else begin
                    // a simultaneous read+write request is served as a write
                    bus.ramWEN = bus.dWEN;
                    bus.ramREN = bus.dREN & ~bus.dWEN;
                    if (bus.ramstate == ACCESS) begin
                        bus.dwait = 1'b0;
                        nxt = IDLE;
                        starve_nxt = !bus.iREN ? '0
                                   : (starve_cnt == CW'(STARVE_MAX) ? starve_cnt : starve_cnt + 1'b1);
                    end
                end
            end
            default: nxt = IDLE;
        endcase
    end
    always @(posedge CLK)
        if (nRST) assert (!(bus.dREN && bus.dWEN)) else $error("mem_arbiter: dREN and dWEN high together");
endmodule
